// File: rtl/euler_row_driver.sv
// Euler row driver: buffers one row of x + h*dx results, runs the F/R/D request
// handshake against the end-of-row tracker, then drains the row over valid/ready.
module euler_row_driver #(
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 16,
  parameter int ROW_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              rst_sync,
  input  logic              start,
  input  logic [DATA_W-1:0] h,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_dx,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_x,
  input  logic              out_ready,
  input  logic [1:0]        status,
  output logic              F,
  output logic              R,
  output logic              D,
  output logic              busy,
  output logic              sat,
  output logic [15:0]       row_count
);

  localparam int PTR_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(ROW_LEN - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FEED  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ISSR  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_ISSD  = 3'd5;

  localparam logic signed [2*DATA_W:0] S_MAX = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [2*DATA_W:0] S_MIN = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  // Clamp the wide sum into DATA_W; the top bit of the return flags saturation.
  function automatic logic [DATA_W:0] sat_fn(input logic signed [2*DATA_W:0] s);
    if (s > S_MAX)
      return {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
    else if (s < S_MIN)
      return {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, s[DATA_W-1:0]};
  endfunction

  logic [2:0]               state_q, state_d;
  logic [PTR_W-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic                     f_q, f_d, r_q, r_d, d_q, d_d;
  logic                     sat_q, sat_d;
  logic [15:0]              rc_q, rc_d;
  logic signed [DATA_W-1:0] h_q, h_d;
  logic [DATA_W-1:0]        row_buf_q [ROW_LEN];

  logic signed [DATA_W-1:0]   x_s, dx_s;
  logic signed [2*DATA_W-1:0] prod, prod_sh;
  logic signed [2*DATA_W:0]   sum;
  logic [DATA_W:0]            res;
  logic                       feed_beat;

  assign x_s       = in_x;
  assign dx_s      = in_dx;
  assign prod      = h_q * dx_s;
  assign prod_sh   = prod >>> FRAC_W;
  assign sum       = (2*DATA_W+1)'(x_s) + (2*DATA_W+1)'(prod_sh);
  assign res       = sat_fn(sum);
  assign feed_beat = (state_q == S_FEED) && in_valid;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    f_d     = f_q;
    r_d     = r_q;
    d_d     = d_q;
    sat_d   = sat_q;
    rc_d    = rc_q;
    h_d     = h_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FEED;
        h_d     = h;
        sat_d   = 1'b0;
        wr_d    = '0;
      end
      S_FEED: if (in_valid) begin
        wr_d = wr_q + 1'b1;
        if (res[DATA_W]) sat_d = 1'b1;
        if (wr_q == LAST) begin
          f_d     = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: if (status == 2'b10) begin
        f_d     = 1'b0;
        r_d     = 1'b1;
        state_d = S_ISSR;
      end
      S_ISSR: if (status == 2'b11) begin
        r_d     = 1'b0;
        rd_d    = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: if (out_ready) begin
        rd_d = rd_q + 1'b1;
        if (rd_q == LAST) begin
          d_d     = 1'b1;
          state_d = S_ISSD;
        end
      end
      S_ISSD: if (status == 2'b00) begin
        d_d     = 1'b0;
        rc_d    = rc_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      f_q     <= 1'b0;
      r_q     <= 1'b0;
      d_q     <= 1'b0;
      sat_q   <= 1'b0;
      rc_q    <= '0;
      h_q     <= '0;
    end else if (rst_sync) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      f_q     <= 1'b0;
      r_q     <= 1'b0;
      d_q     <= 1'b0;
      sat_q   <= 1'b0;
      rc_q    <= '0;
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      f_q     <= f_d;
      r_q     <= r_d;
      d_q     <= d_d;
      sat_q   <= sat_d;
      rc_q    <= rc_d;
      h_q     <= h_d;
    end
  end

  // Row storage carries data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (feed_beat) row_buf_q[wr_q] <= res[DATA_W-1:0];
  end

  assign in_ready  = (state_q == S_FEED);
  assign out_valid = (state_q == S_DRAIN);
  assign out_x     = row_buf_q[rd_q];
  assign F         = f_q;
  assign R         = r_q;
  assign D         = d_q;
  assign busy      = (state_q != S_IDLE);
  assign sat       = sat_q;
  assign row_count = rc_q;

endmodule

// File: tb/tb_euler_row_driver.sv
// Directed bench for euler_row_driver: scoreboard of modelled results, negedge
// tracker model, and F/R/D pulse monitor.
module tb_euler_row_driver;
  localparam int DATA_W  = 32;
  localparam int FRAC_W  = 16;
  localparam int ROW_LEN = 8;

  logic clk = 1'b0, rst_async = 1'b1, rst_sync = 1'b0, start = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] h = '0, in_x = '0, in_dx = '0;
  logic in_ready, out_valid, F, R, D, busy, sat;
  logic [31:0] out_x;
  logic [15:0] row_count;
  logic [1:0]  status;

  logic [1:0] trk_q = 2'b00, man_status = 2'b00;
  logic       auto_trk = 1'b1;

  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] xa[ROW_LEN], dxa[ROW_LEN];
  logic [31:0] hv_cur;
  bit          row_sat;

  int cyc = 0, f_hi = 0, r_hi = 0, d_hi = 0, multi = 0;
  int f_rise = 0, r_rise = 0, d_rise = 0;
  logic f_prev = 1'b0, r_prev = 1'b0, d_prev = 1'b0;

  euler_row_driver #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ROW_LEN(ROW_LEN)) dut (
    .clk(clk), .rst_async(rst_async), .rst_sync(rst_sync), .start(start), .h(h),
    .in_valid(in_valid), .in_x(in_x), .in_dx(in_dx), .in_ready(in_ready),
    .out_valid(out_valid), .out_x(out_x), .out_ready(out_ready), .status(status),
    .F(F), .R(R), .D(D), .busy(busy), .sat(sat), .row_count(row_count)
  );

  always #5 clk = ~clk;

  assign status = auto_trk ? trk_q : man_status;

  always @(negedge clk) begin
    if (F) trk_q <= 2'b10;
    else if (R) trk_q <= 2'b11;
    else if (D) trk_q <= 2'b00;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    f_hi = f_hi + int'(F);
    r_hi = r_hi + int'(R);
    d_hi = d_hi + int'(D);
    if (int'(F) + int'(R) + int'(D) > 1) multi = multi + 1;
    if (F && !f_prev) f_rise = cyc;
    if (R && !r_prev) r_rise = cyc;
    if (D && !d_prev) d_rise = cyc;
    f_prev = F;
    r_prev = R;
    d_prev = D;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] hv, xv, dxv, output bit s);
    longint p, q, sm, mx, mn;
    mx = 64'sd2147483647;
    mn = -mx - 1;
    p  = longint'($signed(hv)) * longint'($signed(dxv));
    q  = p >>> FRAC_W;
    sm = longint'($signed(xv)) + q;
    s  = 1'b0;
    if (sm > mx) begin s = 1'b1; return 32'h7FFFFFFF; end
    if (sm < mn) begin s = 1'b1; return 32'h80000000; end
    return sm[31:0];
  endfunction

  task automatic start_row(input logic [31:0] hv, input bit hold);
    h      = hv;
    hv_cur = hv;
    start  = 1'b1;
    row_sat = 1'b0;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic feed_row();
    bit s;
    for (int i = 0; i < ROW_LEN; i++) begin
      in_valid = 1'b1;
      in_x     = xa[i];
      in_dx    = dxa[i];
      for (int t = 0; t < 100 && !in_ready; t++) @(negedge clk);
      if (!in_ready) begin
        chk("feed_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      exp_q.push_back(model(hv_cur, xa[i], dxa[i], s));
      if (s) row_sat = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // mode 0: out_ready always high; mode 1: out_ready pattern 1,0,0 repeating
  task automatic drain_row(input int mode, input int nbeats);
    int got = 0, t = 0;
    logic [31:0] held = '0, e;
    bit stalled = 1'b0;
    while (got < nbeats && t < 300) begin
      out_ready = (mode == 0) ? 1'b1 : ((t % 3) == 0);
      if (stalled && out_valid) chk("stall_stable", out_x, held);
      stalled = 1'b0;
      if (out_valid) chk("D_early", D, 0);
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        chk("out_x", out_x, e);
        got++;
      end else if (out_valid) begin
        held    = out_x;
        stalled = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
    if (got < nbeats) chk("drain_timeout", got, nbeats);
    if (nbeats == ROW_LEN) chk("D_set", D, 1);
  endtask

  task automatic wait_done();
    for (int t = 0; t < 100 && busy; t++) @(negedge clk);
    chk("row_done", busy, 0);
  endtask

  task automatic fill_basic();
    for (int i = 0; i < ROW_LEN; i++) begin
      xa[i]  = 32'h00020000;
      dxa[i] = 32'h00010000;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < ROW_LEN; i++) begin
      xa[i]  = $urandom;
      dxa[i] = $urandom;
    end
  endtask

  initial begin
    int f0, r0, d0, viol;
    logic [15:0] rc0;
    logic [31:0] hr;

    repeat (2) @(negedge clk);
    rst_async = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_F", F, 0);
    chk("rst_R", R, 0);
    chk("rst_D", D, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sat", sat, 0);
    chk("rst_row_count", row_count, 0);

    // asynchronous reset in DRAIN after three accepted beats
    fill_basic();
    start_row(32'h00001000, 1'b0);
    feed_row();
    drain_row(0, 3);
    chk("pre_arst_out_valid", out_valid, 1);
    rst_async = 1'b1;
    #1;
    chk("arst_F", F, 0);
    chk("arst_R", R, 0);
    chk("arst_D", D, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_row_count", row_count, 0);
    @(negedge clk);
    rst_async = 1'b0;
    exp_q.delete();

    // synchronous reset: takes effect only at the next posedge
    start_row(32'h00001000, 1'b0);
    feed_row();
    drain_row(0, 3);
    rst_sync = 1'b1;
    #1;
    chk("srst_before_edge_busy", busy, 1);
    @(posedge clk);
    #1;
    chk("srst_F", F, 0);
    chk("srst_R", R, 0);
    chk("srst_D", D, 0);
    chk("srst_out_valid", out_valid, 0);
    chk("srst_busy", busy, 0);
    chk("srst_row_count", row_count, 0);
    @(negedge clk);
    rst_sync = 1'b0;
    exp_q.delete();
    @(negedge clk);

    // basic row with responsive tracker
    f0 = f_hi; r0 = r_hi; d0 = d_hi;
    start_row(32'h00001000, 1'b0);
    feed_row();
    chk("basic_model", exp_q[0], 32'h00021000);
    drain_row(0, ROW_LEN);
    wait_done();
    repeat (2) @(negedge clk);
    chk("basic_F_cycles", f_hi - f0, 1);
    chk("basic_R_cycles", r_hi - r0, 1);
    chk("basic_D_cycles", d_hi - d0, 1);
    chk("basic_R_after_F", r_rise - f_rise, 1);
    chk("basic_D_after_R", d_rise > r_rise, 1);
    chk("basic_row_count", row_count, 1);
    chk("basic_sat", sat, 0);

    // negative and saturating elements
    for (int i = 0; i < ROW_LEN; i++) begin
      xa[i]  = 32'(i) << 16;
      dxa[i] = 32'h00008000;
    end
    xa[0] = 32'h00000000; dxa[0] = 32'hFFFF0000;
    xa[1] = 32'h7FFF0000; dxa[1] = 32'h00100000;
    xa[2] = 32'h80000000; dxa[2] = 32'hFFF00000;
    start_row(32'h00010000, 1'b0);
    feed_row();
    chk("neg_model", exp_q[0], 32'hFFFF0000);
    chk("satp_model", exp_q[1], 32'h7FFFFFFF);
    chk("satn_model", exp_q[2], 32'h80000000);
    drain_row(0, ROW_LEN);
    wait_done();
    chk("sat_sticky", sat, row_sat);
    chk("sat_row_count", row_count, 2);

    // stalled tracker: F held, then R held through a stray 01
    fill_basic();
    auto_trk   = 1'b0;
    man_status = 2'b00;
    start_row(32'h00001000, 1'b0);
    chk("sat_cleared_on_start", sat, 0);
    feed_row();
    viol = 0;
    for (int t = 0; t < 20; t++) begin
      if (F !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) viol++;
      @(negedge clk);
    end
    chk("stall_F_hold", viol, 0);
    man_status = 2'b10;
    @(negedge clk);
    chk("eor_F_drop", F, 0);
    chk("eor_R_rise", R, 1);
    man_status = 2'b01;
    viol = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (R !== 1'b1 || out_valid !== 1'b0) viol++;
    end
    chk("stray01_R_hold", viol, 0);
    man_status = 2'b11;
    @(negedge clk);
    chk("ready_R_drop", R, 0);
    chk("ready_out_valid", out_valid, 1);
    auto_trk = 1'b1;
    drain_row(0, ROW_LEN);
    wait_done();
    chk("stall_row_count", row_count, 3);

    // backpressure with random data
    fill_random();
    hr = $urandom;
    start_row(hr, 1'b0);
    feed_row();
    drain_row(1, ROW_LEN);
    wait_done();
    chk("bp_row_count", row_count, 4);
    chk("bp_sat", sat, row_sat);

    // back-to-back rows with start held high
    rc0 = row_count;
    hr  = 32'h00003000;
    start_row(hr, 1'b1);
    for (int r = 0; r < 3; r++) begin
      fill_random();
      feed_row();
      drain_row(0, ROW_LEN);
    end
    start = 1'b0;
    wait_done();
    chk("b2b_row_count", row_count, rc0 + 16'd3);
    chk("b2b_queue_empty", exp_q.size(), 0);
    chk("frd_onehot", multi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/euler_row_driver.md
Name: euler_row_driver

Overview:
- Producer-side controller for the Euler row handshake. Accepts a row of ROW_LEN (x, dx) element pairs and computes x_next = x + h*dx in signed fixed point.
- Buffers the row and drives the F / R / D handshake toward the end-of-row tracker. It advances only on that tracker's 2-bit status {end_of_row, data_ready}.
- Streams the buffered results downstream with a valid/ready handshake.

Parameters:
- DATA_W, 32: signed fixed-point word width of x, dx, h and results.
- FRAC_W, 16: fractional bits (Q(DATA_W-FRAC_W).FRAC_W).
- ROW_LEN, 8: elements per row, >= 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_async  in  1  reset, asynchronous, active-high.
- rst_sync  in  1  synchronous active-high reset; same effect as rst_async, at the next posedge.
- start  in  1  begin a row; sampled only in IDLE.
- h  in  DATA_W  step size, signed; sampled on start.
- in_valid  in  1  input pair valid.
- in_x  in  DATA_W  current state value, signed.
- in_dx  in  DATA_W  derivative, signed.
- in_ready  out  1  high only in FEED.
- out_valid  out  1  result valid (DRAIN).
- out_x  out  DATA_W  result, buffer[rd_ptr].
- out_ready  in  1  downstream accept.
- status  in  2  tracker state: 00 idle, 10 end-of-row, 11 data-ready.
- F  out  1  end-of-row request, level-held.
- R  out  1  results-ready request, level-held.
- D  out  1  drained request, level-held.
- busy  out  1  state != IDLE.
- sat  out  1  sticky: some element of current row saturated; cleared on start.
- row_count  out  16  completed rows, wraps 0xFFFF->0.

Behaviour:
- Reset (either source):
  - state=IDLE; wr_ptr=rd_ptr=0; F=R=D=0; sat=0; row_count=0; h_reg=0.
  - Buffer contents are not cleared; they are don't-care.
  - Reset mid-row abandons the row with no F/R/D issued.
- FSM:
  - IDLE: start=1 -> FEED. Latch h_reg=h, clear sat, wr_ptr=0.
  - FEED: each in_valid&in_ready beat writes sat_result into buffer[wr_ptr] at that posedge and increments wr_ptr. On the beat with wr_ptr==ROW_LEN-1, set F=1 and go to WAIT_EOR.
  - WAIT_EOR: hold F=1 until status==10 is sampled. Then F=0, R=1, go to ISSUE_R.
  - ISSUE_R: hold R=1 until status==11. Then R=0, rd_ptr=0, go to DRAIN.
  - DRAIN: out_valid=1, out_x=buffer[rd_ptr]. Each out_valid&out_ready beat increments rd_ptr. On the beat with rd_ptr==ROW_LEN-1, set D=1 and go to ISSUE_D.
  - ISSUE_D: hold D=1 until status==00. Then D=0, row_count+1, go to IDLE.
- Status values other than the awaited one (including 01) are ignored; the request stays held indefinitely.
- Handshake timing: with a tracker that updates on negedge, each request is high exactly 1 cycle. At most one of F/R/D is high at any time.
- start outside IDLE is ignored. Back-to-back rows: start may be high in the cycle IDLE is re-entered.
- Throughput: 1 element/cycle in FEED and DRAIN. out_ready low stalls with out_x stable.
- Arithmetic:
  - p = signed(h_reg) * signed(in_dx), 2*DATA_W bits.
  - q = p >>> FRAC_W (arithmetic shift).
  - s = sign-extended in_x + q, 2*DATA_W+1 bits.
  - If s > 2^(DATA_W-1)-1, result = 0x7FF..F and sat=1. If s < -2^(DATA_W-1), result = 0x800..0 and sat=1. Otherwise result = s[DATA_W-1:0].
  - Truncation toward -inf; no rounding.
- ROW_LEN=1: the first FEED beat sets F; the first DRAIN beat sets D.

Test Plan:
- Basic step: start with h=0x00001000, ROW_LEN=8, all pairs x=0x00020000, dx=0x00010000, responsive tracker -> 8 outputs of 0x00021000. F, R and D each high 1 cycle in that order. row_count=1, sat=0.
- Negative/saturation: pair0 x=0, dx=0xFFFF0000, h=0x00010000 -> 0xFFFF0000. Pair1 x=0x7FFF0000, dx=0x00100000 -> 0x7FFFFFFF, sat=1. Pair2 x=0x80000000, dx=0xFFF00000 -> 0x80000000.
- Stalled handshake: tracker holds status=00 for 20 cycles after F -> F stays 1, in_ready=0, no output. Then status=10 -> F drops, R rises next cycle. status=01 injected in ISSUE_R -> R held.
- Backpressure: out_ready toggles 1,0,0,1,... -> each result appears exactly once, in order, stable while stalled. D is set only on the 8th accepted beat.
- Reset mid-operation: rst_async pulse during DRAIN at rd_ptr=3 -> F=R=D=0, out_valid=0, busy=0, row_count unchanged=0 immediately. Repeat with rst_sync -> same effect at the next posedge.
- Back-to-back and wrap: start held high for 3 rows -> start ignored while busy; each row produces 8 outputs; row_count=3. Preload 0xFFFF and complete one row -> row_count=0.
